mux_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the `selector` input of a shared 2:1 multiplexer in front of a single resource port, e.g. instruction fetch vs. load/store sharing one memory port. It accepts level requests, issues registered one-hot grants, and drives the mux select so that only the granted requester's inputs reach the resource. It sits between the requesters' control logic and the `multiplexer2x1` instances that steer the shared port's address and data.

---
 rtl/mux_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_port_arbiter.sv
// mux_port_arbiter: two-requester round-robin arbiter driving the select of a
// shared 2:1 mux. Grants, selector and preempt are all registered.
// Optional forced release on contention is enabled by `ARB_HOLD_LIMIT_EN
// (owner is released after MAX_HOLD cycles while the other side waits).
module mux_port_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   output logic selector,
   output logic busy,
   output logic preempt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

`ifdef ARB_HOLD_LIMIT_EN
   localparam bit HOLD_LIMIT = 1'b1;
`else
   // No forced release: force_rel folds to 0, preempt stays 0 and the
   // hold counter has no observable effect.
   localparam bit HOLD_LIMIT = 1'b0;
`endif

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic       sel_q, sel_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       preempt_q, preempt_d;
   logic       force_rel;
   logic       forced;
   logic       entry;

   // Owner has used its slot while the other side is still waiting
   assign force_rel = HOLD_LIMIT && req0 && req1 && (hold_cnt_q == 8'(MAX_HOLD - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: round-robin on ties, direct handover, optional forced release
   always_comb begin
      state_d = state_q;
      forced  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
            else if (req0)    state_d = OWN0;
            else if (req1)    state_d = OWN1;
         end
         OWN0: begin
            if (req0) begin
               if (force_rel) begin
                  state_d = OWN1;
                  forced  = 1'b1;
               end
            end else begin
               state_d = req1 ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (req1) begin
               if (force_rel) begin
                  state_d = OWN0;
                  forced  = 1'b1;
               end
            end else begin
               state_d = req0 ? OWN0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state/flops only
   always_comb begin
      gnt0     = (state_q == OWN0);
      gnt1     = (state_q == OWN1);
      busy     = (state_q != IDLE);
      selector = sel_q;
      preempt  = preempt_q;
   end

   // Pointer, selector and hold counter follow the next state; selector is
   // left alone in IDLE so the mux does not toggle
   always_comb begin
      entry     = (state_d != IDLE) && (state_d != state_q);
      last_d    = last_q;
      sel_d     = sel_q;
      preempt_d = forced;
      if (entry) begin
         last_d = (state_d == OWN1);
         sel_d  = (state_d == OWN1);
      end
      if (state_d == IDLE)      hold_cnt_d = 8'd0;
      else if (entry)           hold_cnt_d = 8'd0;
      else if (&hold_cnt_q)     hold_cnt_d = hold_cnt_q;
      else                      hold_cnt_d = hold_cnt_q + 8'd1;
   end

   // Datapath registers; last resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= 1'b1;
         sel_q      <= 1'b0;
         hold_cnt_q <= 8'd0;
         preempt_q  <= 1'b0;
      end else begin
         last_q     <= last_d;
         sel_q      <= sel_d;
         hold_cnt_q <= hold_cnt_d;
         preempt_q  <= preempt_d;
      end
   end

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Scoreboard bench for mux_port_arbiter: a behavioural model produces the
// expected {gnt0,gnt1,selector,busy,preempt} when stimulus is driven; the
// entry is popped and compared one edge later.
module tb_mux_port_arbiter;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int MAXH    = 4;
   localparam bit HOLD_EN = 1'b1;
`else
   localparam int MAXH    = 16;
   localparam bit HOLD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 1'b0;
   logic req1 = 1'b0;
   logic gnt0, gnt1, selector, busy, preempt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [4:0] exp_q[$];

   // model state: 0 idle, 1 own0, 2 own1
   int   m_state;
   logic m_last;
   logic m_sel;
   int   m_cnt;

   int exp_pre_cnt;
   int obs_pre_cnt;

   mux_port_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .selector (selector),
      .busy     (busy),
      .preempt  (preempt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_last  = 1'b1;
      m_sel   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic model_step(input logic r0, input logic r1, output logic [4:0] e);
      int   ns;
      logic pre;
      pre = 1'b0;
      ns  = m_state;
      case (m_state)
         0: begin
            if (r0 && r1) ns = m_last ? 1 : 2;
            else if (r0)  ns = 1;
            else if (r1)  ns = 2;
            else          ns = 0;
         end
         1: begin
            if (r0) begin
               if (HOLD_EN && r1 && m_cnt == MAXH - 1) begin ns = 2; pre = 1'b1; end
            end else ns = r1 ? 2 : 0;
         end
         default: begin
            if (r1) begin
               if (HOLD_EN && r0 && m_cnt == MAXH - 1) begin ns = 1; pre = 1'b1; end
            end else ns = r0 ? 1 : 0;
         end
      endcase
      if (ns == 0 || ns != m_state) m_cnt = 0;
      else if (m_cnt < 255)         m_cnt = m_cnt + 1;
      if (ns != 0 && ns != m_state) begin
         m_last = (ns == 2);
         m_sel  = (ns == 2);
      end
      m_state = ns;
      e = {ns == 1, ns == 2, m_sel, ns != 0, pre};
   endtask

   // drive one cycle of requests, predict, then compare after the edge
   task automatic step(input string tag, input logic r0, input logic r1);
      logic [4:0] e;
      logic [4:0] got;
      @(negedge clk);
      req0 = r0;
      req1 = r1;
      model_step(r0, r1, e);
      exp_q.push_back(e);
      if (e[0]) exp_pre_cnt++;
      @(posedge clk);
      #1;
      got = {gnt0, gnt1, selector, busy, preempt};
      if (preempt) obs_pre_cnt++;
      chk(tag, 32'(got), 32'(exp_q.pop_front()));
      chk("mutex", 32'(gnt0 & gnt1), 32'd0);
   endtask

   int         run;
   int         prev_owner;
   logic       r0f, r1f;
   logic [1:0] prev_g;

   initial begin
      model_reset();
      exp_pre_cnt = 0;
      obs_pre_cnt = 0;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", 32'({gnt0, gnt1, selector, busy, preempt}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // first tie goes to requester 0
      step("tie_first", 1'b1, 1'b1);
      chk("tie_gnt0", 32'({gnt0, selector}), 32'b10);

      // single request pulse on req1
      step("idle0", 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("single1", 1'b0, 1'b1);
      step("single_rel", 1'b0, 1'b0);
      chk("sel_hold", 32'({busy, selector}), 32'b01);
      step("idle_sel", 1'b0, 1'b0);

      // handover with no bubble
      for (int i = 0; i < 3; i++) step("ho_own0", 1'b1, 1'b0);
      step("ho_wait", 1'b1, 1'b1);
      step("ho_switch", 1'b0, 1'b1);
      chk("ho_gnt", 32'({gnt0, gnt1}), 32'b01);
      step("ho_idle", 1'b0, 1'b0);

      // fairness: owner drops for one cycle after 3 granted cycles
      run = 0;
      prev_owner = -1;
      prev_g = 2'b00;
      for (int i = 0; i < 40; i++) begin
         r0f = 1'b1;
         r1f = 1'b1;
         if (run == 3 && m_state == 1) r0f = 1'b0;
         if (run == 3 && m_state == 2) r1f = 1'b0;
         step("rr", r0f, r1f);
         if ({gnt0, gnt1} != 2'b00 && {gnt0, gnt1} != prev_g) begin
            if (prev_owner >= 0) chk("rr_alt", 32'(gnt1), 32'(prev_owner == 0));
            prev_owner = gnt1 ? 1 : 0;
         end
         prev_g = {gnt0, gnt1};
         run = (m_state == 0) ? 0 : ((r0f && r1f) ? run + 1 : 1);
      end
      step("rr_end", 1'b0, 1'b0);

      // asynchronous reset mid-cycle while gnt1 is high
      step("pre_rst", 1'b0, 1'b1);
      step("pre_rst2", 1'b0, 1'b1);
      chk("pre_rst_gnt1", 32'(gnt1), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 32'({gnt0, gnt1, selector, busy, preempt}), 32'd0);
      model_reset();
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_tie", 1'b1, 1'b1);
      chk("post_rst_gnt0", 32'({gnt0, selector}), 32'b10);

      // both requesters held for 100 cycles
      exp_pre_cnt = 0;
      obs_pre_cnt = 0;
      for (int i = 0; i < 100; i++) step("hold", 1'b1, 1'b1);
      chk("preempt_cnt", 32'(obs_pre_cnt), 32'(exp_pre_cnt));
`ifndef ARB_HOLD_LIMIT_EN
      chk("hold_no_limit", 32'({gnt0, gnt1, preempt}), 32'b100);
      chk("no_preempt", 32'(obs_pre_cnt), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
